muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer beside the EX-stage ALU of the 5-stage MIPS core. Executes mult, multu, div and divu over several cycles and owns the architectural HI/LO registers. Raises a stall request so the hazard logic freezes IF/ID/EX while an operation is in flight. Supports mthi/mtlo writes and cancellation by pipeline flush.

---
 rtl/muldiv_ctrl_if.sv | 37 +++
 rtl/muldiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Bundle of the multiply/divide sequencer's pipeline-side signals.
//
// Handshake: start is an issue pulse that is taken only when busy is low
// and flush is low in that cycle; there is no separate ready signal, so the
// issuer must hold the instruction in EX (stall_req) until done. Once taken,
// busy (== stall_req) stays high until the result is written, and done
// pulses for one cycle in the first idle cycle afterwards. mthi/mtlo are
// accepted only while busy is low; flush cancels an operation in flight.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, src_a, src_b, flush, mthi, mtlo, wdata,
    input  busy, stall_req, done, div_zero, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, src_a, src_b, flush, mthi, mtlo, wdata,
    output busy, stall_req, done, div_zero, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// One result bit per cycle: PREP takes magnitudes, RUN iterates WIDTH times,
// FIX applies sign correction and writes HI/LO.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  md
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, RUN = 2'd2, FIX = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [WIDTH-1:0]    a_q, b_q, bm_q;
  logic                neg_res_q, neg_rem_q;
  logic [CW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [WIDTH:0]      rem_q;
  logic [WIDTH-1:0]    hi_q, lo_q;
  logic                done_q, dz_q;

  logic                is_div, signed_op;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      mul_sum, div_shift, div_diff;
  logic                div_ge;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo_raw, rem_raw, quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign signed_op = ~op_q[0];

  // Datapath arithmetic: magnitudes, one iteration step, and sign fix-up.
  always_comb begin
    a_mag     = (signed_op && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
    b_mag     = (signed_op && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
    // Multiply: add multiplier into the upper half when the low bit is set,
    // keep the carry, then shift the whole accumulator right by one.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? bm_q : {WIDTH{1'b0}})};
    // Divide: dividend bits leave the top of acc_q low half; quotient bits
    // enter at its bottom.
    div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, bm_q};
    div_ge    = ~div_diff[WIDTH];
    quo_raw   = acc_q[WIDTH-1:0];
    rem_raw   = rem_q[WIDTH-1:0];
    prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_res_q ? (~quo_raw + 1'b1) : quo_raw;
    rem_fix   = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
  end

  // Next-state logic; flush overrides every busy state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md.start && !md.flush) state_d = PREP;
      PREP:    state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md.flush && state_q != IDLE) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture, iteration, HI/LO writes and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      bm_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (md.mthi) hi_q <= md.wdata;
          if (md.mtlo) lo_q <= md.wdata;
          if (md.start && !md.flush) begin
            op_q <= md.op;
            a_q  <= md.src_a;
            b_q  <= md.src_b;
          end
        end
        PREP: begin
          acc_q     <= {{WIDTH{1'b0}}, a_mag};
          bm_q      <= b_mag;
          rem_q     <= '0;
          cnt_q     <= CW'(WIDTH - 1);
          neg_res_q <= signed_op & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q <= signed_op & a_q[WIDTH-1];
        end
        RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (is_div) begin
            acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
            rem_q <= div_ge ? div_diff : div_shift;
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!md.flush) begin
            done_q <= 1'b1;
            if (!is_div) begin
              {hi_q, lo_q} <= prod_fix;
            end else if (b_q == '0) begin
              // Divide by zero: architecturally defined result, not the
              // iteration output.
              lo_q <= '1;
              hi_q <= a_q;
              dz_q <= 1'b1;
            end else begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy      = (state_q != IDLE);
  assign md.stall_req = (state_q != IDLE);
  assign md.done      = done_q;
  assign md.div_zero  = dz_q;
  assign md.hi        = hi_q;
  assign md.lo        = lo_q;
  assign md.dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, signed/unsigned results,
// divide-by-zero, overflow, flush, back-to-back issue and async reset.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  muldiv_ctrl_if #(.WIDTH(W)) bus ();

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus.slave)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; reports ticks taken and busy samples seen.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0; busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
    n_vec++; if ({bus.done, bus.div_zero} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {bus.done, bus.div_zero}); end
    n_vec++; if ({bus.hi, bus.lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multu_max();
    int c, bc;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_vec++; if (bus.stall_req !== 1'b1) begin n_err++; $display("FAIL multu_stall: got %b want 1", bus.stall_req); end
    tick(); tick();
    n_vec++; if (bus.dbg_state !== 2'd2) begin n_err++; $display("FAIL multu_state_run: got %0d want 2", bus.dbg_state); end
    wait_done(c, bc);
    c += 2; bc += 2;
    n_vec++; if (c !== 34) begin n_err++; $display("FAIL multu_latency: got %0d want 34", c); end
    n_vec++; if (bc !== 34) begin n_err++; $display("FAIL multu_busy_cycles: got %0d want 34", bc); end
    n_vec++; if (bus.hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    n_vec++; if (bus.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    n_vec++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL multu_dz: got %b want 0", bus.div_zero); end
    tick();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL multu_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_signed();
    int c, bc;
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(c, bc);
    n_vec++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_err++; $display("FAIL mult_neg: got %h want ffffffffffffffeb", {bus.hi, bus.lo}); end
    tick();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(c, bc);
    n_vec++; if (bus.lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg_quo: got %h want fffffffd", bus.lo); end
    n_vec++; if (bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_neg_rem: got %h want ffffffff", bus.hi); end
    tick();
    issue(2'b11, 32'd100, 32'd7);
    wait_done(c, bc);
    n_vec++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin n_err++; $display("FAIL divu_basic: got %h want 000000020000000e", {bus.hi, bus.lo}); end
    tick();
  endtask

  task automatic test_div_zero_ovf();
    int c, bc;
    issue(2'b11, 32'd100, 32'd0);
    wait_done(c, bc);
    n_vec++; if (c !== 34) begin n_err++; $display("FAIL divz_latency: got %0d want 34", c); end
    n_vec++; if (bus.div_zero !== 1'b1) begin n_err++; $display("FAIL divz_flag: got %b want 1", bus.div_zero); end
    n_vec++; if ({bus.hi, bus.lo} !== {32'd100, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL divz_result: got %h want 00000064ffffffff", {bus.hi, bus.lo}); end
    tick();
    n_vec++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL divz_pulse_width: got %b want 0", bus.div_zero); end
    issue(2'b10, 32'hFFFF_FFF0, 32'd0);
    wait_done(c, bc);
    n_vec++; if ({bus.div_zero, bus.hi, bus.lo} !== {1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL divz_signed: got %h want 1fffffff0ffffffff", {bus.div_zero, bus.hi, bus.lo}); end
    tick();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(c, bc);
    n_vec++; if ({bus.hi, bus.lo} !== {32'd0, 32'h8000_0000}) begin n_err++; $display("FAIL div_ovf: got %h want 0000000080000000", {bus.hi, bus.lo}); end
    n_vec++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL div_ovf_flag: got %b want 0", bus.div_zero); end
    tick();
  endtask

  task automatic test_flush();
    int c, bc;
    logic done_seen;
    logic [W-1:0] lo_before;
    lo_before = 32'h8000_0000;
    bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
    tick();
    bus.mthi = 1'b0;
    n_vec++; if (bus.hi !== 32'h0000_1234) begin n_err++; $display("FAIL mthi_idle: got %h want 00001234", bus.hi); end
    issue(2'b11, 32'd10, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    n_vec++; if ({bus.hi, bus.lo} !== {32'h0000_1234, lo_before}) begin n_err++; $display("FAIL flush_hilo: got %h want %h", {bus.hi, bus.lo}, {32'h0000_1234, lo_before}); end
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.div_zero === 1'b1) done_seen = 1'b1;
      tick();
    end
    n_vec++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL flush_no_done: got %b want 0", done_seen); end
    issue(2'b11, 32'd10, 32'd3);
    wait_done(c, bc);
    n_vec++; if ({bus.hi, bus.lo} !== {32'd1, 32'd3}) begin n_err++; $display("FAIL post_flush_divu: got %h want 0000000100000003", {bus.hi, bus.lo}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int c, bc;
    issue(2'b01, 32'd5, 32'd7);
    wait_done(c, bc);
    n_vec++; if (bus.lo !== 32'd35) begin n_err++; $display("FAIL b2b_first: got %h want 00000023", bus.lo); end
    // second op issued in the done cycle, together with an mthi write
    bus.mthi = 1'b1; bus.wdata = 32'h0000_AAAA;
    issue(2'b01, 32'd2, 32'd3);
    bus.mthi = 1'b0;
    n_vec++; if ({bus.busy, bus.hi} !== {1'b1, 32'h0000_AAAA}) begin n_err++; $display("FAIL b2b_accept: got %h want 10000aaaa", {bus.busy, bus.hi}); end
    for (int i = 0; i < 5; i++) tick();
    bus.op = 2'b01; bus.src_a = 32'd9; bus.src_b = 32'd9; bus.start = 1'b1;
    bus.mtlo = 1'b1; bus.wdata = 32'h0000_DEAD;
    tick();
    bus.start = 1'b0; bus.mtlo = 1'b0;
    n_vec++; if (bus.lo !== 32'd35) begin n_err++; $display("FAIL mtlo_busy_ignored: got %h want 00000023", bus.lo); end
    wait_done(c, bc);
    c += 6;
    n_vec++; if (c !== 34) begin n_err++; $display("FAIL b2b_latency: got %0d want 34", c); end
    n_vec++; if ({bus.hi, bus.lo} !== {32'd0, 32'd6}) begin n_err++; $display("FAIL b2b_result: got %h want 0000000000000006", {bus.hi, bus.lo}); end
    tick();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_mid_start_ignored: got %b want 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h0000_0055;
    tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    n_vec++; if ({bus.hi, bus.lo} !== {32'h55, 32'h55}) begin n_err++; $display("FAIL mthi_mtlo_both: got %h want 0000005500000055", {bus.hi, bus.lo}); end
    issue(2'b01, 32'd123, 32'd456);
    for (int i = 0; i < 10; i++) tick();
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({bus.busy, bus.stall_req} !== 2'b00) begin n_err++; $display("FAIL async_rst_busy: got %b want 00", {bus.busy, bus.stall_req}); end
    n_vec++; if ({bus.hi, bus.lo} !== 64'd0) begin n_err++; $display("FAIL async_rst_hilo: got %h want 0", {bus.hi, bus.lo}); end
    #1 rst = 1'b0;
    tick();
    n_vec++; if ({bus.busy, bus.done} !== 2'b00) begin n_err++; $display("FAIL post_rst_idle: got %b want 00", {bus.busy, bus.done}); end
  endtask

  // Test sequence and final report
  initial begin
    idle_inputs();
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero_ovf();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
